// File: rtl/ucaspian_pkg.sv
// Shared types and constants for the uCaspian step controller.
package ucaspian_pkg;

  localparam int TIME_W         = 32;
  localparam int NUM_STEP_UNITS = 5;

  localparam int UNIT_FIRE_DISPATCH = 0;
  localparam int UNIT_AXON          = 1;
  localparam int UNIT_NEURON        = 2;
  localparam int UNIT_DENDRITE      = 3;
  localparam int UNIT_SYNAPSE       = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_DONE,
    ST_ADVANCE,
    ST_GUARD
  } step_state_e;

  // Adds an 8-bit increment to a time value, clamping at all-ones.
  function automatic logic [TIME_W-1:0] sat_add_time(input logic [TIME_W-1:0] a,
                                                     input logic [7:0]        b);
    logic [TIME_W:0] sum;
    sum = {1'b0, a} + {{(TIME_W - 7){1'b0}}, b};
    return sum[TIME_W] ? {TIME_W{1'b1}} : sum[TIME_W-1:0];
  endfunction

endpackage

// File: rtl/ucaspian_target_accum.sv
// Saturating run-length target accumulator with a one-cycle accept handshake.
module ucaspian_target_accum
  import ucaspian_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic [7:0]        value_i,
  input  logic              waiting_i,
  output logic              ack_o,
  output logic [TIME_W-1:0] target_o
);

  logic              ack_q, ack_d;
  logic [TIME_W-1:0] target_q, target_d;

  // An offer is taken only when the previous cycle did not ack, giving one ack per assertion.
  always_comb begin
    ack_d    = 1'b0;
    target_d = target_q;
    if (clr) begin
      target_d = '0;
    end else if (waiting_i && !ack_q) begin
      target_d = sat_add_time(target_q, value_i);
      ack_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q    <= 1'b0;
      target_q <= '0;
    end else begin
      ack_q    <= ack_d;
      target_q <= target_d;
    end
  end

  assign ack_o    = ack_q;
  assign target_o = target_q;

endmodule

// File: rtl/ucaspian_step_ctrl.sv
// Network time-step controller: waits for all units to settle, then advances time by one.
module ucaspian_step_ctrl
  import ucaspian_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int GUARD_CYCLES  = 2,
  parameter int STEP_TIMEOUT  = 1023
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear_act,
  input  logic                      clear_config,
  input  logic [7:0]                time_target_value,
  input  logic                      time_target_waiting,
  output logic                      time_target_ack,
  input  logic [NUM_STEP_UNITS-1:0] unit_step_done,
  input  logic                      output_fire_waiting,
  output logic                      next_step,
  output logic [TIME_W-1:0]         time_current,
  output logic                      time_update,
  input  logic                      time_sent,
  output logic                      time_remaining,
  output logic                      core_active,
  output logic                      step_stall
);

  localparam int              WD_W       = $clog2(STEP_TIMEOUT + 1);
  localparam logic [3:0]      SETTLE_MAX = 4'(SETTLE_CYCLES);
  localparam logic [3:0]      GUARD_LAST = 4'(GUARD_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(STEP_TIMEOUT - 1);

  logic              clr, all_done;
  logic [TIME_W-1:0] target_time;
  logic [3:0]        settle_inc;

  step_state_e       state_q, state_d;
  logic [3:0]        settle_q, settle_d;
  logic [3:0]        guard_q, guard_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [TIME_W-1:0] time_current_q, time_current_d;
  logic              time_update_q, time_update_d;
  logic              next_step_q, next_step_d;
  logic              time_remaining_q, time_remaining_d;
  logic              step_stall_q, step_stall_d;

  assign clr      = clear_act | clear_config;
  assign all_done = unit_step_done[UNIT_FIRE_DISPATCH] & unit_step_done[UNIT_AXON] &
                    unit_step_done[UNIT_NEURON] & unit_step_done[UNIT_DENDRITE] &
                    unit_step_done[UNIT_SYNAPSE] & ~output_fire_waiting;

  ucaspian_target_accum u_accum (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .value_i   (time_target_value),
    .waiting_i (time_target_waiting),
    .ack_o     (time_target_ack),
    .target_o  (target_time)
  );

  // Settle count saturates so it can sit at its limit while the last update is unconsumed.
  assign settle_inc = (settle_q == SETTLE_MAX) ? SETTLE_MAX : settle_q + 4'd1;

  always_comb begin
    state_d          = state_q;
    settle_d         = settle_q;
    guard_d          = guard_q;
    wd_d             = wd_q;
    time_current_d   = time_current_q;
    time_update_d    = time_update_q;
    next_step_d      = 1'b0;
    time_remaining_d = target_time > time_current_q;
    step_stall_d     = step_stall_q;

    if (time_update_q && time_sent) time_update_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        settle_d = '0;
        guard_d  = '0;
        wd_d     = '0;
        if (time_remaining_q) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (wd_q == WD_LAST) step_stall_d = 1'b1;
        else                 wd_d         = wd_q + 1'b1;
        settle_d = all_done ? settle_inc : 4'd0;
        if (all_done && (settle_inc == SETTLE_MAX) && !time_update_q) begin
          state_d        = ST_ADVANCE;
          next_step_d    = 1'b1;
          time_current_d = time_current_q + TIME_W'(1);
          time_update_d  = 1'b1;
          settle_d       = '0;
        end
      end
      ST_ADVANCE: begin
        state_d = ST_GUARD;
        guard_d = '0;
      end
      ST_GUARD: begin
        if (guard_q == GUARD_LAST) begin
          state_d = ST_IDLE;
          guard_d = '0;
        end else begin
          guard_d = guard_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (clr) begin
      state_d          = ST_IDLE;
      settle_d         = '0;
      guard_d          = '0;
      wd_d             = '0;
      time_current_d   = '0;
      time_update_d    = 1'b0;
      next_step_d      = 1'b0;
      time_remaining_d = 1'b0;
      step_stall_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      settle_q         <= '0;
      guard_q          <= '0;
      wd_q             <= '0;
      time_current_q   <= '0;
      time_update_q    <= 1'b0;
      next_step_q      <= 1'b0;
      time_remaining_q <= 1'b0;
      step_stall_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      settle_q         <= settle_d;
      guard_q          <= guard_d;
      wd_q             <= wd_d;
      time_current_q   <= time_current_d;
      time_update_q    <= time_update_d;
      next_step_q      <= next_step_d;
      time_remaining_q <= time_remaining_d;
      step_stall_q     <= step_stall_d;
    end
  end

  assign next_step      = next_step_q;
  assign time_current   = time_current_q;
  assign time_update    = time_update_q;
  assign time_remaining = time_remaining_q;
  assign core_active    = time_remaining_q & ~clear_act & ~clear_config;
  assign step_stall     = step_stall_q;

endmodule

// File: tb/tb_ucaspian_step_ctrl.sv
// Directed and randomized checks of ucaspian_step_ctrl against a rule-based reference model.
module tb_ucaspian_step_ctrl;
  import ucaspian_pkg::*;

  localparam int SETTLE = 2;
  localparam int GUARD  = 2;
  localparam int TOUT   = 16;

  logic        clk = 1'b0;
  logic        reset, clear_act, clear_config;
  logic [7:0]  time_target_value;
  logic        time_target_waiting, time_target_ack;
  logic [4:0]  unit_step_done;
  logic        output_fire_waiting, next_step;
  logic [31:0] time_current;
  logic        time_update, time_sent, time_remaining, core_active, step_stall;

  ucaspian_step_ctrl #(.SETTLE_CYCLES(SETTLE), .GUARD_CYCLES(GUARD), .STEP_TIMEOUT(TOUT)) dut (
    .clk(clk), .reset(reset), .clear_act(clear_act), .clear_config(clear_config),
    .time_target_value(time_target_value), .time_target_waiting(time_target_waiting),
    .time_target_ack(time_target_ack), .unit_step_done(unit_step_done),
    .output_fire_waiting(output_fire_waiting), .next_step(next_step),
    .time_current(time_current), .time_update(time_update), .time_sent(time_sent),
    .time_remaining(time_remaining), .core_active(core_active), .step_stall(step_stall)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  int          upd_age = 0;
  int          sent_lat = 0;
  bit          auto_sent = 0;
  bit          rand_fire = 0;
  logic        prev_upd = 1'b0;
  logic [31:0] prev_tc = '0;
  longint      model_target = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; samples 1 time unit after the edge, checks every step pulse, runs the time_sent responder.
  task automatic tick();
    @(posedge clk); #1;
    if (next_step === 1'b1) begin
      chk("step_not_under_backpressure", 32'(prev_upd), 32'd0);
      chk("step_time_inc", time_current, 32'(prev_tc + 32'd1));
      chk("step_sets_update", 32'(time_update), 32'd1);
      pulses++;
    end
    prev_upd = time_update;
    prev_tc  = time_current;
    if (auto_sent && time_update === 1'b1) begin
      if (upd_age >= sent_lat) time_sent = 1'b1;
      upd_age++;
    end else begin
      time_sent = 1'b0;
      upd_age   = 0;
    end
    if (rand_fire) output_fire_waiting = ($urandom_range(0, 3) == 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic add_target(input logic [7:0] v);
    longint t;
    time_target_value   = v;
    time_target_waiting = 1'b1;
    tick();
    time_target_waiting = 1'b0;
    t = model_target + longint'(v);
    model_target = (t > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : t;
    chk("ack_pulse", 32'(time_target_ack), 32'd1);
    chk("target_value", dut.u_accum.target_q, 32'(model_target));
    tick();
    chk("ack_one_cycle", 32'(time_target_ack), 32'd0);
  endtask

  task automatic do_clear();
    clear_config = 1'b1;
    tick();
    clear_config = 1'b0;
    auto_sent = 0; rand_fire = 0; output_fire_waiting = 1'b0;
    model_target = 0;
    chk("clr_time_current", time_current, 32'd0);
    chk("clr_flags", {28'd0, time_update, time_remaining, step_stall, next_step}, 32'd0);
  endtask

  task automatic wait_step(output bit found);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (next_step === 1'b1) found = 1;
    end
  endtask

  initial begin
    int  p0, sum, n, budget;
    bit  found;
    reset = 1'b0; clear_act = 1'b0; clear_config = 1'b0;
    time_target_value = '0; time_target_waiting = 1'b0; unit_step_done = '0;
    output_fire_waiting = 1'b0; time_sent = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_time_current", time_current, 32'd0);
    chk("rst_outputs", {26'd0, next_step, time_update, time_remaining, core_active,
                        step_stall, time_target_ack}, 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    reset = 1'b1;
    tick();

    // Three steps with prompt time_sent
    unit_step_done = 5'h1F; auto_sent = 1; sent_lat = 0;
    p0 = pulses;
    add_target(8'd3);
    chk("remaining_lag", 32'(time_remaining), 32'd1);
    chk("core_active", 32'(core_active), 32'd1);
    ticks(40);
    chk("run3_pulses", 32'(pulses - p0), 32'd3);
    chk("run3_time", time_current, 32'd3);
    chk("run3_remaining", 32'(time_remaining), 32'd0);
    chk("run3_idle", 32'(dut.state_q), 32'(ST_IDLE));
    do_clear();

    // One unit busy holds off the step until it has settled
    unit_step_done = 5'h1B; auto_sent = 1;
    p0 = pulses;
    add_target(8'd2);
    ticks(50);
    chk("busy_no_step", 32'(pulses - p0), 32'd0);
    unit_step_done = 5'h1F;
    tick();
    chk("settle_1", 32'(next_step), 32'd0);
    tick();
    chk("settle_2", 32'(next_step), 32'd1);
    ticks(30);
    chk("busy_total", 32'(pulses - p0), 32'd2);
    do_clear();

    // Withheld time_sent allows only one step
    unit_step_done = 5'h1F; auto_sent = 0;
    p0 = pulses;
    add_target(8'd5);
    ticks(100);
    chk("bp_pulses", 32'(pulses - p0), 32'd1);
    chk("bp_time", time_current, 32'd1);
    chk("bp_update", 32'(time_update), 32'd1);
    auto_sent = 1;
    ticks(60);
    chk("bp_release_pulses", 32'(pulses - p0), 32'd5);
    chk("bp_release_time", time_current, 32'd5);
    do_clear();

    // Target saturation
    unit_step_done = 5'h00;
    force dut.u_accum.target_q = 32'hFFFF_FFF0;
    #1;
    release dut.u_accum.target_q;
    model_target = 64'hFFFF_FFF0;
    add_target(8'hFF);
    add_target(8'h05);
    chk("sat_target", dut.u_accum.target_q, 32'hFFFF_FFFF);
    do_clear();

    // Clear beats an ADVANCE and a simultaneous target offer
    unit_step_done = 5'h1F; auto_sent = 1;
    add_target(8'd3);
    wait_step(found);
    chk("adv_seen", 32'(found), 32'd1);
    clear_act = 1'b1; time_target_waiting = 1'b1; time_target_value = 8'd7;
    tick();
    clear_act = 1'b0; time_target_waiting = 1'b0;
    chk("clr_win_time", time_current, 32'd0);
    chk("clr_win_flags", {27'd0, next_step, time_update, time_remaining, step_stall,
                          time_target_ack}, 32'd0);
    chk("clr_win_target", dut.u_accum.target_q, 32'd0);
    tick();
    chk("clr_win_no_ack", 32'(time_target_ack), 32'd0);
    chk("clr_win_state", 32'(dut.state_q), 32'(ST_IDLE));
    model_target = 0; auto_sent = 0;

    // Watchdog
    unit_step_done = 5'h00; auto_sent = 1;
    p0 = pulses;
    add_target(8'd1);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (dut.state_q == ST_WAIT_DONE) found = 1;
      else tick();
    end
    chk("wd_enter_wait", 32'(found), 32'd1);
    ticks(TOUT - 1);
    chk("wd_before", 32'(step_stall), 32'd0);
    tick();
    chk("wd_at_timeout", 32'(step_stall), 32'd1);
    unit_step_done = 5'h1F;
    ticks(20);
    chk("wd_recover_pulses", 32'(pulses - p0), 32'd1);
    chk("wd_sticky", 32'(step_stall), 32'd1);
    do_clear();

    // Reset mid-step aborts immediately
    unit_step_done = 5'h1F; auto_sent = 1;
    add_target(8'd4);
    wait_step(found);
    chk("rstmid_adv_seen", 32'(found), 32'd1);
    tick();
    reset = 1'b0;
    #1;
    chk("rstmid_async", {time_current[27:0], next_step, time_update, time_remaining,
                         step_stall}, 32'd0);
    p0 = pulses;
    ticks(2);
    reset = 1'b1;
    ticks(20);
    chk("rstmid_no_pulse", 32'(pulses - p0), 32'd0);
    model_target = 0;
    do_clear();

    // Randomized runs: total steps must equal the accumulated target
    for (int trial = 0; trial < 8; trial++) begin
      unit_step_done = 5'h1F; auto_sent = 1; rand_fire = 1;
      sent_lat = $urandom_range(0, 3);
      p0 = pulses; sum = 0;
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        logic [7:0] v;
        v = 8'($urandom_range(0, 2));
        sum += int'(v);
        add_target(v);
      end
      budget = 60 * sum + 40;
      ticks(budget);
      chk("rand_pulses", 32'(pulses - p0), 32'(sum));
      chk("rand_time", time_current, 32'(sum));
      chk("rand_remaining", 32'(time_remaining), 32'd0);
      do_clear();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/ucaspian_step_ctrl.md
UCASPIAN_STEP_CTRL -- requirements
Module: ucaspian_step_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: consecutive cycles all_done must hold before a step advances (range 1..15).
REQ-002 SHALL have parameter GUARD_CYCLES, default 2: cycles after next_step during which done inputs are ignored (range 1..15).
REQ-003 SHALL have parameter STEP_TIMEOUT, default 1023: WAIT_DONE cycles before step_stall sets.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Ports (name dir width meaning):
- clk in 1 clock
- reset in 1 async active-low reset
- clear_act in 1 sync clear of activity state
- clear_config in 1 sync clear of configuration
- time_target_value in 8 run-length increment
- time_target_waiting in 1 increment offered
- time_target_ack out 1 one-cycle accept pulse
- unit_step_done in 5 per-unit idle: [0] fire_dispatch, [1] axon, [2] neuron, [3] dendrite, [4] synapse
- output_fire_waiting in 1 output fire pending
- next_step out 1 one-cycle step-advance pulse
- time_current out 32 network time
- time_update out 1 new time pending
- time_sent in 1 time value consumed
- time_remaining out 1 target_time > time_current
- core_active out 1 core running
- step_stall out 1 sticky timeout flag

Function
REQ-006 all_done SHALL be the AND of unit_step_done[4:0] and !output_fire_waiting.
REQ-007 States SHALL be IDLE, WAIT_DONE, ADVANCE, GUARD.
REQ-008 IDLE->WAIT_DONE when time_remaining=1; otherwise stay in IDLE.
REQ-009 WAIT_DONE SHALL count consecutive all_done cycles; a 0 on all_done resets the count; ->ADVANCE when count reaches SETTLE_CYCLES and time_update=0.
REQ-010 ADVANCE SHALL last exactly one cycle with next_step=1, increment time_current by 1, set time_update=1, then ->GUARD.
REQ-011 GUARD SHALL hold GUARD_CYCLES cycles, then ->IDLE.
REQ-012 next_step SHALL be a registered Moore output (high only in ADVANCE).
REQ-013 time_update SHALL clear the cycle after time_sent is sampled high; time_sent while time_update=0 SHALL be ignored.
REQ-014 A step SHALL NOT advance while time_update=1 (backpressure); the settle count holds at SETTLE_CYCLES.
REQ-015 Target accumulation: if time_target_waiting=1 and time_target_ack=0, then next cycle target_time += value and time_target_ack=1 for one cycle; accepted in every state.
REQ-016 target_time SHALL be 32-bit and saturate at 0xFFFFFFFF; time_current SHALL wrap only via clear.
REQ-017 time_remaining SHALL be registered from (target_time > time_current), one cycle lag.
REQ-018 core_active SHALL equal time_remaining && !clear_act && !clear_config.
REQ-019 A watchdog SHALL count WAIT_DONE cycles; at STEP_TIMEOUT, step_stall=1 and stays until clear or reset; the FSM keeps waiting.
REQ-020 clear_act or clear_config SHALL synchronously force state IDLE, all counters, target_time, time_current and all outputs to 0; clear wins over every simultaneous event, including a target increment.

Reset
REQ-021 While reset=0: state IDLE; all outputs, counters, target_time and time_current are 0.
REQ-022 Reset assertion mid-step (ADVANCE or GUARD) SHALL abort immediately with no further next_step pulse.

Structure
REQ-023 ucaspian_pkg SHALL hold the state enum, NUM_STEP_UNITS=5, the unit index constants and TIME_W=32.
REQ-024 The saturating target accumulator with its ack handshake SHALL be sub-module ucaspian_target_accum; the remaining logic is flat.

Verification
REQ-025 Add target 3 with unit_step_done=5'h1F and time_sent returned one cycle after each update -> exactly 3 next_step pulses, time_current=3, then time_remaining=0 and the FSM in IDLE.
REQ-026 Target 2 with unit_step_done[2] low for 50 cycles -> no next_step until bit 2 has been high SETTLE_CYCLES cycles.
REQ-027 Target 5 with time_sent withheld for 100 cycles -> a single next_step only; time_current=1 until time_sent arrives.
REQ-028 target_time=0xFFFFFFF0 plus value 0xFF -> target_time=0xFFFFFFFF, with one ack per waiting assertion.
REQ-029 clear_act in the same cycle as an ADVANCE and a target increment -> all zeros next cycle, no ack, step_stall=0.
REQ-030 STEP_TIMEOUT=16 with done held low -> step_stall=1 after 16 WAIT_DONE cycles and still 1 after done recovers.
